genius_sequence_player: RTL and testbench



---
 rtl/genius_sequence_player.sv | 191 +++++++++++++++++++
 tb/tb_genius_sequence_player.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/genius_sequence_player.sv
// genius_sequence_player
// Plays a stored Simon colour sequence on four LEDs and a buzzer. For each
// step, one LED and the matching tone stay on for ON_CYCLES cycles. All
// outputs are then blanked for GAP_CYCLES cycles.
//
// State table:
//   state  | meaning
//   IDLE   | waiting for start; outputs low, step_idx 0
//   ON     | current step's LED and tone lit
//   GAP    | everything dark between steps
//   DONE   | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          play request (sampled in IDLE) / synchronous stop
//   seq_len, seq_data     number of steps and 2-bit colour codes (step i at [2i+1:2i])
//   led_green..led_yellow lamp drives (codes 00,01,10,11)
//   tone_en, tone_sel     buzzer enable and colour code of the lit step
//   busy, done            playing flag / completion pulse
//   step_idx              step currently on or in gap
module genius_sequence_player #(
    parameter int  MAX_LEN    = 32,
    parameter int  ON_CYCLES  = 25000000,
    parameter int  GAP_CYCLES = 12500000,
    localparam int LEN_W      = $clog2(MAX_LEN + 1),
    localparam int IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LEN_W-1:0]     seq_len,
    input  logic [2*MAX_LEN-1:0] seq_data,
    output logic                 led_green,
    output logic                 led_red,
    output logic                 led_blue,
    output logic                 led_yellow,
    output logic                 tone_en,
    output logic [1:0]           tone_sel,
    output logic                 busy,
    output logic                 done,
    output logic [IDX_W-1:0]     step_idx
);

    localparam int MAX_CYC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_nxt;
    logic [LEN_W-1:0]     step_q, step_nxt;
    logic [LEN_W-1:0]     len_q, len_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic [2*MAX_LEN-1:0] seq_q, seq_nxt;
    logic [LEN_W-1:0]     len_clamped;

    logic [3:0]           leds_q, leds_d;
    logic                 tone_en_d;
    logic [1:0]           tone_sel_d;
    logic                 busy_d;
    logic                 done_d;
    logic [1:0]           code_nxt;

    assign len_clamped = (seq_len > LEN_MAX) ? LEN_MAX : seq_len;

    // State, snapshot and output registers. The outputs are decoded from the
    // next state, so each one appears in the same cycle as its state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            seq_q    <= '0;
            leds_q   <= '0;
            tone_en  <= 1'b0;
            tone_sel <= 2'b00;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            step_q   <= step_nxt;
            len_q    <= len_nxt;
            cnt_q    <= cnt_nxt;
            seq_q    <= seq_nxt;
            leds_q   <= leds_d;
            tone_en  <= tone_en_d;
            tone_sel <= tone_sel_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

    always_comb begin
        state_nxt = state_q;
        step_nxt  = step_q;
        len_nxt   = len_q;
        cnt_nxt   = cnt_q;
        seq_nxt   = seq_q;
        case (state_q)
            S_IDLE: begin
                step_nxt = '0;
                cnt_nxt  = '0;
                if (start && !abort) begin
                    seq_nxt = seq_data;
                    len_nxt = len_clamped;
                    if (len_clamped == '0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ON;
                        cnt_nxt   = ON_LOAD;
                    end
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = GAP_LOAD;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - 1'b1;
                end else if (step_q == len_q - LEN_W'(1)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_ON;
                    step_nxt  = step_q + LEN_W'(1);
                    cnt_nxt   = ON_LOAD;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                step_nxt  = '0;
                cnt_nxt   = '0;
            end
            default: begin
                state_nxt = S_IDLE;
                step_nxt  = '0;
                cnt_nxt   = '0;
            end
        endcase
        // Abort overrides everything once a play is in progress.
        if (abort && state_q != S_IDLE) begin
            state_nxt = S_IDLE;
            step_nxt  = '0;
            cnt_nxt   = '0;
        end
    end

    always_comb begin
        code_nxt = 2'b00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (step_nxt == LEN_W'(i)) code_nxt = seq_nxt[2*i +: 2];
        end
        leds_d     = 4'b0000;
        tone_en_d  = 1'b0;
        tone_sel_d = 2'b00;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_nxt)
            S_ON: begin
                leds_d     = 4'b0001 << code_nxt;
                tone_en_d  = 1'b1;
                tone_sel_d = code_nxt;
                busy_d     = 1'b1;
            end
            S_GAP:   busy_d = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    assign led_green  = leds_q[0];
    assign led_red    = leds_q[1];
    assign led_blue   = leds_q[2];
    assign led_yellow = leds_q[3];
    assign step_idx   = step_q[IDX_W-1:0];

endmodule

// File: tb/tb_genius_sequence_player.sv
// Testbench for genius_sequence_player with MAX_LEN=8, ON_CYCLES=4 and
// GAP_CYCLES=2. When the driver issues a start that should be accepted, it
// expands the play into a per-cycle list of expected outputs. A monitor
// compares the DUT against that list on every falling edge. Cycles that have
// no expectation must show all outputs at zero.
module tb_genius_sequence_player;

    localparam int MAX_LEN = 8;
    localparam int ON_C    = 4;
    localparam int GAP_C   = 2;
    localparam int STEP_C  = ON_C + GAP_C;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  seq_len = '0;
    logic [15:0] seq_data = '0;
    logic        led_green, led_red, led_blue, led_yellow;
    logic        tone_en;
    logic [1:0]  tone_sel;
    logic        busy, done;
    logic [2:0]  step_idx;

    genius_sequence_player #(
        .MAX_LEN   (MAX_LEN),
        .ON_CYCLES (ON_C),
        .GAP_CYCLES(GAP_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .seq_len   (seq_len),
        .seq_data  (seq_data),
        .led_green (led_green),
        .led_red   (led_red),
        .led_blue  (led_blue),
        .led_yellow(led_yellow),
        .tone_en   (tone_en),
        .tone_sel  (tone_sel),
        .busy      (busy),
        .done      (done),
        .step_idx  (step_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] leds;
        logic       te;
        logic [1:0] ts;
        logic       busy;
        logic       done;
        logic [2:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   next_free = 0;   // first edge at which the player is back in IDLE
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, logic [3:0] l, logic te, logic [1:0] ts,
                                 logic b, logic d, logic [2:0] idx);
        exp_t e;
        e.cyc = c; e.leds = l; e.te = te; e.ts = ts; e.busy = b; e.done = d; e.idx = idx;
        exp_q.push_back(e);
    endfunction

    // One cycle of stimulus: the inputs are set after a falling edge and the
    // reference model decides what the next rising edge does.
    task automatic drive(input logic s, input logic a, input logic [3:0] l, input logic [15:0] d);
        int k;
        int n;
        logic [1:0] code;
        @(negedge clk);
        start = s; abort = a; seq_len = l; seq_data = d;
        k = cyc + 1;
        if (a && k < next_free) begin
            while (exp_q.size() > 0 && exp_q[$].cyc >= k) void'(exp_q.pop_back());
            next_free = k + 1;
        end else if (s && !a && k >= next_free) begin
            n = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
            for (int st = 0; st < n; st++) begin
                code = d[2*st +: 2];
                for (int c = 0; c < ON_C; c++)
                    push(k + st*STEP_C + c, 4'b0001 << code, 1'b1, code, 1'b1, 1'b0, 3'(st));
                for (int c = 0; c < GAP_C; c++)
                    push(k + st*STEP_C + ON_C + c, 4'b0000, 1'b0, 2'b00, 1'b1, 1'b0, 3'(st));
            end
            push(k + n*STEP_C, 4'b0000, 1'b0, 2'b00, 1'b0, 1'b1, (n == 0) ? 3'd0 : 3'(n - 1));
            next_free = k + n*STEP_C + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 4'd0, 16'h0000);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            logic [11:0] act, expv;
            e.cyc = cyc; e.leds = '0; e.te = 1'b0; e.ts = '0;
            e.busy = 1'b0; e.done = 1'b0; e.idx = '0;
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++; errors++;
                $display("FAIL stale_expectation cyc=%0d: expected entry for cyc %0d never matched",
                         cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) e = exp_q.pop_front();
            act  = {led_yellow, led_blue, led_red, led_green, tone_en, tone_sel, busy, done, step_idx};
            expv = {e.leds, e.te, e.ts, e.busy, e.done, e.idx};
            checks++;
            if (act !== expv) begin
                errors++;
                $display("FAIL outputs cyc=%0d got leds=%b te=%b ts=%b busy=%b done=%b idx=%0d, expected leds=%b te=%b ts=%b busy=%b done=%b idx=%0d",
                         cyc, act[11:8], act[7], act[6:5], act[4], act[3], act[2:0],
                         expv[11:8], expv[7], expv[6:5], expv[4], expv[3], expv[2:0]);
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1 mon_en = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Three steps: green, blue, yellow.
        drive(1'b1, 1'b0, 4'd3, 16'h0038);
        idle(24);

        // Zero-length play.
        drive(1'b1, 1'b0, 4'd0, 16'hFFFF);
        idle(4);

        // Length above MAX_LEN is clamped to eight steps.
        drive(1'b1, 1'b0, 4'd12, 16'h1B6C);
        idle(55);

        // Start and data change during play are ignored; then abort.
        drive(1'b1, 1'b0, 4'd3, 16'h0039);
        idle(3);
        drive(1'b1, 1'b0, 4'd3, 16'hFFFF);
        idle(2);
        drive(1'b0, 1'b1, 4'd3, 16'h0000);
        idle(25);

        // Abort and start together while idle: abort wins.
        drive(1'b1, 1'b1, 4'd2, 16'h0005);
        idle(4);

        // Asynchronous reset in the middle of an ON window.
        drive(1'b1, 1'b0, 4'd3, 16'h0024);
        idle(2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        next_free = 0;
        #1;
        checks++;
        if ({led_green, led_red, led_blue, led_yellow, tone_en, busy, done} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got leds=%b%b%b%b te=%b busy=%b done=%b, expected all 0",
                     led_yellow, led_blue, led_red, led_green, tone_en, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 4'd2, 16'h0009);
        idle(16);

        // Start held high with a one-step sequence.
        for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 4'd1, 16'h0002);
        idle(10);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 6) == 0, ($urandom % 40) == 0,
                  4'($urandom % 16), 16'($urandom));
        end
        idle(MAX_LEN*STEP_C + 6);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
